// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 frame checker: byte-per-clock Ethernet CRC over payload+FCS,
// residue check at frame end, length check, abort on restart, saturating frame counters.
module crc32_frame_checker #(
  parameter int unsigned MIN_LEN = 5,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             d_valid,
  input  logic [7:0]       d_in,
  input  logic             d_finish,
  output logic             done,
  output logic             crc_ok,
  output logic             len_err,
  output logic             abort,
  output logic             busy,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 2);
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_d, abort_d, crc_ok_d, len_err_d;
  logic             good_inc;
  logic [1:0]       bad_inc;

  // Reflected CRC-32 update, one byte LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Next-state, CRC/length datapath and result evaluation.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    crc_ok_d  = crc_ok;
    len_err_d = len_err;
    good_inc  = 1'b0;
    bad_inc   = 2'd0;

    if (d_valid) begin
      if (load) begin
        crc_d   = crc_byte(CRC_INIT, d_in);
        len_d   = LEN_W'(1);
        state_d = ACTIVE;
        if (state_q == ACTIVE) begin
          abort_d = 1'b1;
          bad_inc = 2'd1;
        end
      end else if (state_q == ACTIVE) begin
        crc_d = crc_byte(crc_q, d_in);
        len_d = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
      end

      // Last byte is already folded into crc_d/len_d here.
      if (d_finish && (load || state_q == ACTIVE)) begin
        done_d    = 1'b1;
        state_d   = IDLE;
        crc_ok_d  = (crc_d == RESIDUE);
        len_err_d = (len_d < LEN_MIN) || (len_d > LEN_MAX);
        if (crc_ok_d && !len_err_d) good_inc = 1'b1;
        else                        bad_inc  = bad_inc + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      crc_q    <= CRC_INIT;
      len_q    <= '0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      len_err  <= 1'b0;
      abort    <= 1'b0;
      busy     <= 1'b0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      len_q    <= len_d;
      done     <= done_d;
      crc_ok   <= crc_ok_d;
      len_err  <= len_err_d;
      abort    <= abort_d;
      busy     <= (state_d == ACTIVE);
      good_cnt <= sat_add(good_cnt, {1'b0, good_inc});
      bad_cnt  <= sat_add(bad_cnt, bad_inc);
    end
  end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Scoreboard bench for crc32_frame_checker: a default instance and a small one
// (MAX_LEN=16, CNT_W=2) share the same byte stream.
module tb_crc32_frame_checker;

  logic       clk = 1'b0;
  logic       rst, load, d_valid, d_finish;
  logic [7:0] d_in;

  logic        done0, crc_ok0, len_err0, abort0, busy0;
  logic [15:0] good0, bad0;
  logic        done1, crc_ok1, len_err1, abort1, busy1;
  logic [1:0]  good1, bad1;

  crc32_frame_checker dut0 (
    .clk(clk), .rst(rst), .load(load), .d_valid(d_valid), .d_in(d_in), .d_finish(d_finish),
    .done(done0), .crc_ok(crc_ok0), .len_err(len_err0), .abort(abort0), .busy(busy0),
    .good_cnt(good0), .bad_cnt(bad0)
  );

  crc32_frame_checker #(.MIN_LEN(5), .MAX_LEN(16), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .load(load), .d_valid(d_valid), .d_in(d_in), .d_finish(d_finish),
    .done(done1), .crc_ok(crc_ok1), .len_err(len_err1), .abort(abort1), .busy(busy1),
    .good_cnt(good1), .bad_cnt(bad1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic done;
    logic abort;
    logic ok;
    logic le0;
    logic le1;
    int   due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fr[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit open    = 0;
  int mlen    = 0;
  int g0 = 0, b0 = 0, g1 = 0, b1 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int inc, input int max);
    return (v + inc > max) ? max : v + inc;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Pop expected results when due and compare both instances.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      g0 = 0; b0 = 0; g1 = 0; b1 = 0;
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("done0", done0, e.done);
      check("abort0", abort0, e.abort);
      check("done1", done1, e.done);
      check("abort1", abort1, e.abort);
      if (e.done) begin
        check("crc_ok0", crc_ok0, e.ok);
        check("len_err0", len_err0, e.le0);
        check("crc_ok1", crc_ok1, e.ok);
        check("len_err1", len_err1, e.le1);
      end
      g0 = sat(g0, int'(e.done && e.ok && !e.le0), 65535);
      b0 = sat(b0, int'(e.abort) + int'(e.done && !(e.ok && !e.le0)), 65535);
      g1 = sat(g1, int'(e.done && e.ok && !e.le1), 3);
      b1 = sat(b1, int'(e.abort) + int'(e.done && !(e.ok && !e.le1)), 3);
      check("good_cnt0", good0, g0);
      check("bad_cnt0", bad0, b0);
      check("good_cnt1", good1, g1);
      check("bad_cnt1", bad1, b1);
    end else if (done0 || abort0 || done1 || abort1) begin
      check("spurious_pulse", {done0, abort0, done1, abort1}, 0);
    end
  end

  task automatic send(input logic v, input logic l, input logic f, input logic [7:0] d,
                      input logic ok);
    exp_t e;
    d_valid = v; load = l; d_finish = f; d_in = d;
    e.done = 0; e.abort = 0; e.ok = ok; e.le0 = 0; e.le1 = 0;
    if (v) begin
      if (l) begin
        e.abort = open;
        open = 1;
        mlen = 1;
      end else if (open) begin
        mlen++;
      end
      if (f && open) begin
        e.done = 1;
        e.le0  = (mlen < 5) || (mlen > 1518);
        e.le1  = (mlen < 5) || (mlen > 16);
        open   = 0;
      end
    end
    e.due = cyc + 1;
    if (e.done || e.abort) sb.push_back(e);
    @(posedge clk); #1;
    d_valid = 0; load = 0; d_finish = 0;
  endtask

  task automatic send_frame(input bit gaps, input logic ok);
    for (int i = 0; i < fr.size(); i++) begin
      send(1'b1, i == 0, i == fr.size() - 1, fr[i], ok);
      if (gaps && i != fr.size() - 1) send(1'b0, 1'b1, 1'b1, 8'hAA, ok);
    end
  endtask

  task automatic set_good();
    fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
  endtask

  task automatic do_reset();
    sb.delete();
    open = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 0; d_valid = 0; d_finish = 0; d_in = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_done", done0, 0);
    check("rst_crc_ok", crc_ok0, 0);
    check("rst_len_err", len_err0, 0);
    check("rst_abort", abort0, 0);
    check("rst_busy", busy0, 0);
    check("rst_good", good0, 0);
    check("rst_bad", bad0, 0);

    // Reset mid-frame, then a stray finish byte must not complete anything
    set_good();
    send(1'b1, 1'b1, 1'b0, 8'h31, 1'b0);
    send(1'b1, 1'b0, 1'b0, 8'h32, 1'b0);
    send(1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
    check("busy_open", busy0, 1);
    do_reset();
    check("busy_after_rst", busy0, 0);
    check("good_after_rst", good0, 0);
    check("bad_after_rst", bad0, 0);
    send(1'b1, 1'b0, 1'b1, 8'hCB, 1'b0);
    check("busy_stray_fin", busy0, 0);

    // Good frame
    send_frame(1'b0, 1'b1);
    check("busy_after_done", busy0, 0);

    // Corrupt frame, then a back-to-back good copy
    fr[4] = 8'h36;
    send_frame(1'b0, 1'b0);
    set_good();
    send_frame(1'b0, 1'b1);

    // Length boundaries
    fr = {8'h31, 8'h32, 8'h33, 8'h34};
    send_frame(1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b1, 8'h31, 1'b0);
    fr.delete();
    for (int i = 0; i < 17; i++) fr.push_back(8'(i));
    send_frame(1'b0, 1'b0);
    set_good();
    send_frame(1'b1, 1'b1);

    // Restart after 6 bytes, then the good frame
    for (int i = 0; i < 6; i++) send(1'b1, i == 0, 1'b0, fr[i], 1'b0);
    send_frame(1'b0, 1'b1);

    // Restart with a 1-byte frame: abort and done together
    for (int i = 0; i < 3; i++) send(1'b1, i == 0, 1'b0, fr[i], 1'b0);
    send(1'b1, 1'b1, 1'b1, 8'h55, 1'b0);

    // Bad frames to drive the narrow counters into saturation
    fr = {8'h31, 8'h32, 8'h33, 8'h34};
    for (int k = 0; k < 5; k++) send_frame(1'b0, 1'b0);

    // Stray bytes in IDLE
    send(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
    send(1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
    check("busy_stray", busy0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", sb.size(), 0);
    check("final_good0", good0, g0);
    check("final_bad0", bad0, b0);
    check("final_bad1_sat", bad1, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
